// File: rtl/serial_adder6_if.sv
// Handshake/bus bundle for the 6-bit serial adder.
// master: start, A, B out; S, Cout, busy, done in. slave: the reverse.
interface serial_adder6_if;
   logic       start;
   logic [5:0] A;
   logic [5:0] B;
   logic [5:0] S;
   logic       Cout;
   logic       busy;
   logic       done;

   modport master (
      output start,
      output A,
      output B,
      input  S,
      input  Cout,
      input  busy,
      input  done
   );

   modport slave (
      input  start,
      input  A,
      input  B,
      output S,
      output Cout,
      output busy,
      output done
   );
endinterface

// File: rtl/serial_adder6.sv
// Bit-serial 6-bit adder: LSB-first, one full-adder step per clock.
// Ports: clk, rst (async, active-high), bus (slave): start/A/B in,
// S/Cout (registered result), busy (RUN), done (one-cycle pulse) out.
module serial_adder6 (
   input  logic                  clk,
   input  logic                  rst,
   serial_adder6_if.slave        bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nx;

   logic [5:0] a_sr;
   logic [5:0] b_sr;
   logic [5:0] r_sr;
   logic       c_q;
   logic [2:0] cnt;
   logic [5:0] s_q;
   logic       cout_q;

   logic       sum_bit;
   logic       carry_nx;
   logic [5:0] r_nx;
   logic       accept;
   logic       last;

   // Full-adder step on the operand LSBs and the stored carry.
   always_comb begin
      sum_bit  = a_sr[0] ^ b_sr[0] ^ c_q;
      carry_nx = (a_sr[0] & b_sr[0]) |
                 (c_q & (a_sr[0] ^ b_sr[0]));
      // Sum enters from the MSB end so bit 0 lands at r[0] after 6 steps.
      r_nx     = {sum_bit, r_sr[5:1]};
   end

   assign accept = (state != RUN) & bus.start;
   assign last   = (state == RUN) & (cnt == 3'd5);

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE,
         DONE: begin
            if (bus.start) begin
               state_nx = RUN;
            end else begin
               state_nx = IDLE;
            end
         end
         RUN: begin
            if (cnt == 3'd5) begin
               state_nx = DONE;
            end else begin
               state_nx = RUN;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   // Output logic.
   always_comb begin
      bus.busy = 1'b0;
      bus.done = 1'b0;
      unique case (state)
         RUN:     bus.busy = 1'b1;
         DONE:    bus.done = 1'b1;
         default: ;
      endcase
   end

   // Operand, result, carry and counter datapath.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr <= '0;
         b_sr <= '0;
         r_sr <= '0;
         c_q  <= 1'b0;
         cnt  <= '0;
      end else if (accept) begin
         a_sr <= bus.A;
         b_sr <= bus.B;
         c_q  <= 1'b0;
         cnt  <= '0;
      end else if (state == RUN) begin
         a_sr <= {1'b0, a_sr[5:1]};
         b_sr <= {1'b0, b_sr[5:1]};
         r_sr <= r_nx;
         c_q  <= carry_nx;
         cnt  <= cnt + 3'd1;
      end
   end

   // Visible result only changes on the bit-5 step, never mid-run.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s_q    <= '0;
         cout_q <= 1'b0;
      end else if (last) begin
         s_q    <= r_nx;
         cout_q <= carry_nx;
      end
   end

   assign bus.S    = s_q;
   assign bus.Cout = cout_q;

endmodule

// File: doc/serial_adder6.md
SERIAL_ADDER6 -- requirements
Module: serial_adder6

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have port start, input, 1 bit: request to add A and B, sampled on clk rising edge.
REQ-004 The block SHALL have port A, input, 6 bits: unsigned addend, sampled only when start is accepted.
REQ-005 The block SHALL have port B, input, 6 bits: unsigned addend, sampled only when start is accepted.
REQ-006 The block SHALL have port S, output, 6 bits: registered sum of the last completed operation.
REQ-007 The block SHALL have port Cout, output, 1 bit: registered carry-out of the last completed operation.
REQ-008 The block SHALL have port busy, output, 1 bit: high while an operation is in progress.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse marking that S and Cout were just updated.

Function
REQ-010 The block SHALL implement a 3-state FSM: IDLE, RUN, DONE.
REQ-011 In IDLE or DONE, start=1 at a rising edge SHALL be accepted: capture A and B into internal 6-bit shift registers, clear the internal carry to 0, clear the 3-bit bit counter to 0, and enter RUN.
REQ-012 In IDLE or DONE, start=0 SHALL lead to IDLE.
REQ-013 In RUN, each cycle SHALL compute one full-adder step on the LSBs of the operand shift registers and the carry: sum bit = a^b^c, carry = ab | c(a^b).
REQ-014 In RUN, each cycle SHALL shift the sum bit into an internal result shift register from the MSB end, shift both operand registers right by one, store the new carry, and increment the counter.
REQ-015 RUN SHALL last exactly 6 cycles, bit 0 through bit 5, LSB first.
REQ-016 On the RUN edge that processes bit 5 (counter=5), the block SHALL load S with the completed 6-bit result and Cout with the final carry, and enter DONE.
REQ-017 Result arithmetic: {Cout,S} SHALL equal A+B as a 7-bit unsigned value; no overflow truncation beyond 7 bits is possible.
REQ-018 Latency: if start is accepted at edge k, done SHALL be 1 and S/Cout SHALL be valid after edge k+6.
REQ-019 busy SHALL be 1 exactly when state=RUN.
REQ-020 done SHALL be 1 exactly when state=DONE, i.e. for one cycle per operation.
REQ-021 S and Cout SHALL hold their previous values throughout RUN and IDLE; they change only at completion or reset.
REQ-022 start during RUN SHALL be ignored: no restart, and A/B changes SHALL have no effect on the operation in progress.
REQ-023 Back-to-back: start=1 while in DONE SHALL begin a new operation with no idle gap; done SHALL still pulse for exactly one cycle.
REQ-024 A and B SHALL need to be valid only at the accepting edge.

Reset
REQ-025 rst=1 SHALL asynchronously force: state=IDLE, S=0, Cout=0, busy=0, done=0, operand/result shift registers=0, carry=0, counter=0.
REQ-026 rst asserted mid-RUN SHALL abort the operation without updating S or Cout with a partial result, and without asserting done.
REQ-027 start SHALL be ignored in any cycle where rst=1; the first possible acceptance is the first rising edge with rst=0.

Verification
REQ-028 Reset, then A=0, B=0, start pulse -> busy=1 for 6 cycles, then done=1 for 1 cycle, S=0, Cout=0.
REQ-029 A=63, B=1 -> S=0, Cout=1 at done; A=63, B=63 -> S=62, Cout=1.
REQ-030 A=21, B=42 -> S=63, Cout=0; change A/B and pulse start at RUN cycle 3 -> result unchanged, completion still at k+6.
REQ-031 Hold start=1 continuously with A=5, B=9, then with A=10, B=20 presented in the DONE cycle -> done pulses every 7 cycles, S=14 then S=30, with S holding 14 during the second RUN.
REQ-032 Start A=40, B=30, assert rst at RUN cycle 4 -> S=0, Cout=0, busy=0 immediately, no done pulse; next operation A=40, B=30 -> S=6, Cout=1.
